fifo_drain_ctrl: RTL and testbench
==================================

Name: fifo_drain_ctrl

Overview:
Downstream consumer of the FIFO block. Monitors FIFO_empty/FIFO_almost_empty, generates read_enable, and captures FIFO_data_out one cycle after each read. Presents words to the next stage over a valid/ready handshake through a 2-entry skid buffer. Batches reads until the FIFO leaves almost-empty or a timeout expires, and pauses on a downstream backpressure flag.

Parameters:
DATA_WIDTH, 12, width of FIFO words and data_out
TIMEOUT, 15, idle cycles with non-empty FIFO before draining is forced
CNT_WIDTH, 16, width of the words_sent counter

Ports:
clk  input  1  clock; all logic on posedge
Reset  input  1  synchronous, active-high reset
Enable  input  1  global enable; 0 freezes the FSM and counters
FIFO_data_out  input  DATA_WIDTH  FIFO read data, valid 1 cycle after read_enable
FIFO_empty  input  1  FIFO empty flag
FIFO_almost_empty  input  1  FIFO almost-empty flag
read_enable  output  1  FIFO read strobe, combinational
data_out  output  DATA_WIDTH  head of skid buffer
valid_out  output  1  data_out valid
ready_in  input  1  downstream accepts the word when valid_out&ready_in
pause_in  input  1  downstream almost-full; stops new reads
state_out  output  2  current FSM state encoding
words_sent  output  CNT_WIDTH  count of completed output handshakes, wraps

Behaviour:
- Reset (any cycle, including mid-transfer):
  - state=IDLE, wait_cnt=0, inflight=0, buffer count=0, words_sent=0.
  - valid_out=0, data_out=0, read_enable=0 during the Reset cycle.
  - Any in-flight read word is discarded. Reset must be shared with the FIFO so the two stay consistent.
- FSM states: IDLE=0, DRAIN=1, PAUSE=2. Encoding 3 is illegal and maps to IDLE.
  - IDLE: wait_cnt increments while !FIFO_empty and clears when FIFO_empty.
    - To DRAIN when !FIFO_empty && (!FIFO_almost_empty || wait_cnt==TIMEOUT).
    - wait_cnt saturates at TIMEOUT and clears on leaving IDLE.
  - DRAIN: to PAUSE when pause_in=1 (checked first). Otherwise to IDLE when FIFO_empty && inflight==0.
  - PAUSE: to DRAIN when pause_in=0. Buffered words keep draining to the output while in PAUSE.
- Read issue:
  - pop = valid_out & ready_in.
  - read_enable = Enable & !Reset & state==DRAIN & !pause_in & !FIFO_empty & (count + inflight - pop < 2).
  - This sustains 1 word/cycle when ready_in is held high. No read is ever issued on an empty FIFO.
- Capture:
  - inflight <= read_enable.
  - When inflight=1, FIFO_data_out is pushed into the buffer on that edge.
  - Push and pop in the same cycle keep count unchanged. count never exceeds 2; overflow is a design error.
- Output:
  - valid_out = Enable & (count!=0).
  - data_out is the oldest entry. It holds stable while valid_out & !ready_in.
  - On pop: words_sent increments mod 2^CNT_WIDTH.
- Enable=0:
  - read_enable=0, valid_out=0; state, wait_cnt and words_sent hold.
  - A read issued in the previous cycle is still captured, so no data is lost.
- Ordering: output order equals FIFO read order. No duplication, no drop.

Decomposition:
- Shared package/include: state encodings (IDLE/DRAIN/PAUSE) and the default DATA_WIDTH, so the FIFO and this block share one value.
- One natural sub-module, skid_buffer2: 2-entry, DATA_WIDTH-wide register buffer with push/pop/count and the same sync active-high Reset. The FSM, wait counter and read-issue logic stay in fifo_drain_ctrl.

Test Plan:
- Write 8 words 0x001..0x008 into the FIFO (thresholds low=2), ready_in=1 -> DRAIN entered, 8 consecutive read_enable pulses, data_out 0x001..0x008 on 8 consecutive cycles, words_sent=8, then back to IDLE.
- 1 word (0xABC) in the FIFO, almost_empty=1 -> IDLE for exactly TIMEOUT=15 cycles, then DRAIN. 0xABC is output 2 cycles after DRAIN entry.
- Streaming with ready_in toggling 1,0,0,1 -> count never exceeds 2, data_out stable while stalled, no missing or repeated words (scoreboard against FIFO write order).
- pause_in=1 mid-burst -> read_enable=0 from the same cycle, the 1-2 buffered words still drain, state_out=2. After pause_in=0 -> DRAIN resumes with the next word in sequence.
- Reset asserted 1 cycle after a read_enable (FIFO also reset) -> next cycle valid_out=0, words_sent=0, state_out=0, and the captured word is dropped.
- Enable=0 for 5 cycles during a burst -> read_enable=0, valid_out=0, counters frozen. Afterwards the sequence continues intact, including the word read just before Enable fell.

Source files
------------

// File: rtl/fifo_drain_ctrl_pkg.sv
// fifo_drain_ctrl_pkg
// Shared definitions for the FIFO drain controller and its FIFO producer:
// FSM state encodings and the default data width, so both sides agree.
package fifo_drain_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 12;

  // Encoding 2'd3 is never produced; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_drain_ctrl_skid_buffer2.sv
// skid_buffer2
// Two-entry register buffer between the FIFO capture path and the
// downstream valid/ready handshake. The head entry is always the oldest.
// Ports:
//   clk, Reset      clock, synchronous active-high reset
//   push, din       write din into the buffer this edge
//   pop             remove the head entry this edge (only when count != 0)
//   dout            head entry
//   count           number of valid entries (0..2)
module skid_buffer2
  import fifo_drain_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;

  always_ff @(posedge clk) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          // A push into a full buffer is prevented upstream; drop rather
          // than corrupt count if it ever happens.
          if (count == 2'd0)      head <= din;
          else if (count == 2'd1) tail <= din;
          if (count != 2'd2) count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: occupancy unchanged, queue shifts.
          if (count == 2'd2) begin
            head <= tail;
            tail <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = head;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl
// Drains an upstream FIFO into a valid/ready stream. Waits in IDLE until the
// FIFO holds a batch (leaves almost-empty) or a timeout expires, then reads
// one word per cycle, capturing FIFO read data one cycle after each strobe
// into a 2-entry skid buffer. A downstream pause flag halts new reads while
// buffered words continue to drain.
// Ports:
//   clk, Reset                         clock, synchronous active-high reset
//   Enable                             0 freezes FSM/counters, masks outputs
//   FIFO_data_out, FIFO_empty,
//   FIFO_almost_empty, read_enable     FIFO read interface
//   data_out, valid_out, ready_in      downstream handshake
//   pause_in                           downstream almost-full, stops reads
//   state_out                          FSM state encoding
//   words_sent                         completed handshakes, wrapping
module fifo_drain_ctrl
  import fifo_drain_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic [DATA_WIDTH-1:0] FIFO_data_out,
  input  logic                  FIFO_empty,
  input  logic                  FIFO_almost_empty,
  output logic                  read_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  input  logic                  pause_in,
  output logic [1:0]            state_out,
  output logic [CNT_WIDTH-1:0]  words_sent
);

  localparam int             WW  = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]  TMO = WW'(TIMEOUT);

  state_t                state, state_nx;
  logic [WW-1:0]         wait_cnt;
  logic                  inflight;
  logic                  pop;
  logic [1:0]            count;
  logic [2:0]            occ;
  logic [DATA_WIDTH-1:0] head;

  // State register; Enable=0 holds state.
  always_ff @(posedge clk) begin
    if (Reset)       state <= ST_IDLE;
    else if (Enable) state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (!FIFO_empty && (!FIFO_almost_empty || wait_cnt == TMO))
                  state_nx = ST_DRAIN;
      ST_DRAIN: if (pause_in)                     state_nx = ST_PAUSE;
                else if (FIFO_empty && !inflight) state_nx = ST_IDLE;
      ST_PAUSE: if (!pause_in)                    state_nx = ST_DRAIN;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Output logic. A read is allowed only if the word it returns is
  // guaranteed a buffer slot: occupancy after this cycle's pop stays < 2.
  always_comb begin
    occ         = {1'b0, count} + {2'b00, inflight};
    valid_out   = Enable & !Reset & (count != 2'd0);
    pop         = valid_out & ready_in;
    read_enable = Enable & !Reset & (state == ST_DRAIN) & !pause_in &
                  !FIFO_empty & (occ < (3'd2 + {2'b00, pop}));
    data_out    = Reset ? '0 : head;
    state_out   = state;
  end

  // Idle wait counter: counts cycles with data waiting, saturates at
  // TIMEOUT, and is zero whenever IDLE is not held.
  always_ff @(posedge clk) begin
    if (Reset) begin
      wait_cnt <= '0;
    end else if (Enable) begin
      if (state != ST_IDLE || state_nx != ST_IDLE || FIFO_empty)
        wait_cnt <= '0;
      else if (wait_cnt != TMO)
        wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // Read data returns one cycle after the strobe; capture happens even
  // when Enable has since dropped so nothing already read is lost.
  always_ff @(posedge clk) begin
    if (Reset) begin
      inflight   <= 1'b0;
      words_sent <= '0;
    end else begin
      inflight <= read_enable;
      if (pop) words_sent <= words_sent + CNT_WIDTH'(1);
    end
  end

  skid_buffer2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk   (clk),
    .Reset (Reset),
    .push  (inflight),
    .pop   (pop),
    .din   (FIFO_data_out),
    .dout  (head),
    .count (count)
  );

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl
// Directed bench: a behavioural FIFO feeds the DUT, every word written is
// queued as expected output, and each downstream handshake pops and compares.
module tb_fifo_drain_ctrl;
  import fifo_drain_ctrl_pkg::*;

  localparam int DW  = 12;
  localparam int TMO = 15;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          Reset, Enable, ready_in, pause_in;
  logic          FIFO_empty, FIFO_almost_empty, read_enable, valid_out;
  logic [DW-1:0] FIFO_data_out, data_out;
  logic [1:0]    state_out;
  logic [CW-1:0] words_sent;

  always #5 clk = ~clk;

  fifo_drain_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .Reset             (Reset),
    .Enable            (Enable),
    .FIFO_data_out     (FIFO_data_out),
    .FIFO_empty        (FIFO_empty),
    .FIFO_almost_empty (FIFO_almost_empty),
    .read_enable       (read_enable),
    .data_out          (data_out),
    .valid_out         (valid_out),
    .ready_in          (ready_in),
    .pause_in          (pause_in),
    .state_out         (state_out),
    .words_sent        (words_sent)
  );

  // Behavioural FIFO: registered read data, almost-empty at <= 2 words.
  logic [DW-1:0] fmem [0:255];
  int unsigned   wr_ptr;
  int unsigned   rd_ptr;

  assign FIFO_empty        = (wr_ptr == rd_ptr);
  assign FIFO_almost_empty = ((wr_ptr - rd_ptr) <= 2);

  always @(posedge clk) begin
    if (Reset) begin
      rd_ptr        <= wr_ptr;
      FIFO_data_out <= '0;
    end else if (read_enable) begin
      FIFO_data_out <= fmem[rd_ptr[7:0]];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  logic [DW-1:0] exp_q [$];
  int tests, fails;
  int re_cnt, re_run, re_max, vo_run, vo_max, pop_cnt;
  int n, r0, p0;
  bit stalled;
  logic [DW-1:0] stall_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [DW-1:0] w);
    fmem[wr_ptr[7:0]] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  // One cycle: observe at negedge, then return just after the next posedge.
  task automatic step();
    @(negedge clk);
    if (!Reset) begin
      if (read_enable) begin
        re_cnt++;
        re_run++;
        check("read_on_empty", FIFO_empty, 0);
      end else re_run = 0;
      if (re_run > re_max) re_max = re_run;
      if (valid_out) vo_run++; else vo_run = 0;
      if (vo_run > vo_max) vo_max = vo_run;
      if (stalled && valid_out) check("stall_hold", data_out, stall_data);
      if (valid_out && ready_in) begin
        pop_cnt++;
        if (exp_q.size() == 0) check("sb_extra_word", 0, 1);
        else check("sb_data", data_out, exp_q.pop_front());
      end
      stalled    = valid_out && !ready_in;
      stall_data = data_out;
    end else stalled = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) step();
  endtask

  task automatic wait_reads(input int target, input int budget);
    int k = 0;
    while (re_cnt < target && k < budget) begin
      step();
      k++;
    end
    check("wait_reads_timeout", re_cnt >= target, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; wr_ptr = 0;
    re_cnt = 0; re_run = 0; re_max = 0; vo_run = 0; vo_max = 0; pop_cnt = 0;
    stalled = 0; stall_data = '0;
    Reset = 1'b1; Enable = 1'b1; ready_in = 1'b1; pause_in = 1'b0;

    // Reset state
    step(); step();
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_re", read_enable, 0);
    Reset = 1'b0;
    step();
    check("rst_state", state_out, ST_IDLE);
    check("rst_words", words_sent, 0);
    check("rst_valid2", valid_out, 0);

    // 8-word burst at full rate
    re_cnt = 0; re_max = 0; vo_max = 0;
    for (int i = 1; i <= 8; i++) write_word(DW'(i));
    run(20);
    check("burst_reads", re_cnt, 8);
    check("burst_read_run", re_max, 8);
    check("burst_valid_run", vo_max, 8);
    check("burst_words", words_sent, 8);
    check("burst_idle", state_out, ST_IDLE);
    check("burst_sb_empty", exp_q.size(), 0);

    // Single word below threshold: drain forced by timeout. wait_cnt is 0
    // on the first cycle that sees data, so DRAIN follows TIMEOUT+1 edges.
    write_word(12'hABC);
    n = 0;
    while (state_out != ST_DRAIN && n < 40) begin
      step();
      n++;
    end
    check("timeout_cycles", n, TMO + 1);
    step();
    check("timeout_lat1_valid", valid_out, 0);
    step();
    check("timeout_lat2_valid", valid_out, 1);
    check("timeout_lat2_data", data_out, 12'hABC);
    run(8);
    check("timeout_words", words_sent, 9);
    check("timeout_idle", state_out, ST_IDLE);

    // Backpressure: ready pattern 1,0,0,1
    for (int i = 0; i < 10; i++) write_word(DW'(12'h100 + i));
    for (int i = 0; i < 60; i++) begin
      ready_in = ((i % 4) == 0) || ((i % 4) == 3);
      step();
    end
    ready_in = 1'b1;
    run(10);
    check("stall_sb_empty", exp_q.size(), 0);
    check("stall_words", words_sent, 19);
    check("stall_idle", state_out, ST_IDLE);

    // Pause mid-burst: reads stop at once, the two words in flight drain
    for (int i = 0; i < 10; i++) write_word(DW'(12'h200 + i));
    wait_reads(re_cnt + 4, 30);
    pause_in = 1'b1;
    r0 = re_cnt; p0 = pop_cnt;
    step();
    check("pause_no_read_same_cycle", re_cnt - r0, 0);
    check("pause_state", state_out, ST_PAUSE);
    run(5);
    check("pause_no_reads", re_cnt - r0, 0);
    check("pause_drained", pop_cnt - p0, 2);
    check("pause_state_hold", state_out, ST_PAUSE);
    pause_in = 1'b0;
    step();
    check("pause_resume", state_out, ST_DRAIN);
    run(20);
    check("pause_sb_empty", exp_q.size(), 0);
    check("pause_words", words_sent, 29);

    // Reset one cycle after a read: in-flight word and FIFO contents dropped
    for (int i = 0; i < 6; i++) write_word(DW'(12'h300 + i));
    wait_reads(re_cnt + 1, 30);
    Reset = 1'b1;
    exp_q.delete();
    p0 = pop_cnt;
    #1;
    check("midrst_re", read_enable, 0);
    check("midrst_valid", valid_out, 0);
    check("midrst_data", data_out, 0);
    step();
    Reset = 1'b0;
    #1;
    check("postrst_valid", valid_out, 0);
    check("postrst_words", words_sent, 0);
    check("postrst_state", state_out, ST_IDLE);
    run(10);
    check("postrst_no_output", pop_cnt - p0, 0);

    // Enable low for 5 cycles mid-burst
    for (int i = 0; i < 10; i++) write_word(DW'(12'h400 + i));
    wait_reads(re_cnt + 3, 30);
    Enable = 1'b0;
    #1;
    r0 = re_cnt; p0 = pop_cnt;
    check("en_off_re", read_enable, 0);
    check("en_off_valid", valid_out, 0);
    run(5);
    check("en_off_reads", re_cnt - r0, 0);
    check("en_off_pops", pop_cnt - p0, 0);
    check("en_off_words", words_sent, 1);
    check("en_off_state", state_out, ST_DRAIN);
    Enable = 1'b1;
    run(25);
    check("en_on_sb_empty", exp_q.size(), 0);
    check("en_on_words", words_sent, 10);
    check("en_on_idle", state_out, ST_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
